// File: rtl/alu_op_sequencer.sv
// Multi-cycle arithmetic sequencer: one command over valid/ready, single-cycle ADD/SUB,
// iterative shift-add MUL and restoring DIV/MOD, result held on a valid/ready output.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// EXEC   | iterating MUL/DIV/MOD, one step per clock
// DONE   | result held until res_ready
// HALTED | HALT accepted, frozen until reset
module alu_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_carry,
  output logic             res_err,
  output logic             busy,
  output logic             halted
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_DIV  = 4'b0111;
  localparam logic [3:0] OP_MOD  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE, S_HALTED} state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] imm_data;
  logic             imm_carry, imm_err, go_exec, go_halt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff, div_hi_nxt, div_lo_nxt;
  logic             div_borrow;
  logic [WIDTH-1:0] fin_data;
  logic             fin_carry;

  always_comb begin
    add_sum   = {1'b0, cmd_a} + {1'b0, cmd_b};
    imm_data  = '0;
    imm_carry = 1'b0;
    imm_err   = 1'b0;
    go_exec   = 1'b0;
    go_halt   = 1'b0;
    case (cmd_op)
      OP_ADD: begin
        imm_data  = add_sum[WIDTH-1:0];
        imm_carry = add_sum[WIDTH];
      end
      OP_SUB: begin
        imm_data  = cmd_a - cmd_b;
        imm_carry = (cmd_a < cmd_b);
      end
      OP_MUL: go_exec = 1'b1;
      OP_DIV: begin
        if (cmd_b == '0) begin
          imm_data = '1;
          imm_err  = 1'b1;
        end else begin
          go_exec = 1'b1;
        end
      end
      OP_MOD: begin
        if (cmd_b == '0) begin
          imm_data = cmd_a;
          imm_err  = 1'b1;
        end else begin
          go_exec = 1'b1;
        end
      end
      OP_HALT: go_halt = 1'b1;
      default: imm_err = 1'b1;
    endcase
  end

  // p_hi/p_lo are shared: product high/low for MUL, remainder/quotient for DIV/MOD
  always_comb begin
    mul_sum    = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b_q} : '0);
    mul_hi_nxt = mul_sum[WIDTH:1];
    mul_lo_nxt = {mul_sum[0], p_lo[WIDTH-1:1]};
    div_shift  = {p_hi, p_lo[WIDTH-1]};
    div_borrow = (div_shift < {1'b0, b_q});
    div_diff   = div_shift[WIDTH-1:0] - b_q;
    div_hi_nxt = div_borrow ? div_shift[WIDTH-1:0] : div_diff;
    div_lo_nxt = {p_lo[WIDTH-2:0], ~div_borrow};
    fin_carry  = 1'b0;
    case (op_q)
      OP_DIV:  fin_data = div_lo_nxt;
      OP_MOD:  fin_data = div_hi_nxt;
      default: begin
        fin_data  = mul_lo_nxt;
        fin_carry = |mul_hi_nxt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      op_q      <= '0;
      b_q       <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            b_q       <= cmd_b;
            p_hi      <= '0;
            p_lo      <= cmd_a;
            cnt       <= CW'(WIDTH);
            if (go_halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else if (go_exec) begin
              state <= S_EXEC;
              busy  <= 1'b1;
            end else begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_data  <= imm_data;
              res_zero  <= (imm_data == '0);
              res_carry <= imm_carry;
              res_err   <= imm_err;
            end
          end
        end
        S_EXEC: begin
          cnt  <= cnt - 1'b1;
          p_hi <= (op_q == OP_MUL) ? mul_hi_nxt : div_hi_nxt;
          p_lo <= (op_q == OP_MUL) ? mul_lo_nxt : div_lo_nxt;
          if (cnt == CW'(1)) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            res_valid <= 1'b1;
            res_data  <= fin_data;
            res_zero  <= (fin_data == '0);
            res_carry <= fin_carry;
            res_err   <= 1'b0;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: hand-computed results, latencies, backpressure,
// HALT and reset-abort behaviour.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, res_valid, res_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b, res_data;
  logic        res_zero, res_carry, res_err, busy, halted;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
    .res_carry(res_carry), .res_err(res_err), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int exp_lat, input logic [15:0] exp_data,
                        input logic exp_zero, input logic exp_carry, input logic exp_err);
    int lat;
    int bcnt;
    chk({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    step();
    cmd_valid = 1'b0; cmd_a = 16'hDEAD; cmd_b = 16'hBEEF;
    lat = 1;
    bcnt = 0;
    while (!res_valid && lat < 40) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat - 1));
    chk({tag, "_data"}, 32'(res_data), 32'(exp_data));
    chk({tag, "_flags_zce"}, {29'd0, res_zero, res_carry, res_err},
        {29'd0, exp_zero, exp_carry, exp_err});
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_valid_after_deq"}, 32'(res_valid), 32'd0);
    chk({tag, "_ready_after_deq"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0;
    step(); step();
    reset = 1'b0;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_outputs", {24'd0, res_valid, res_zero, res_carry, res_err, busy, halted, 2'b00}, 32'd0);
    chk("reset_data", 32'(res_data), 32'd0);

    // res_ready with nothing pending must be harmless
    res_ready = 1'b1; step(); res_ready = 1'b0;
    chk("stray_res_ready", {30'd0, cmd_ready, res_valid}, 32'd2);

    run_op("add_20_6",    4'b0011, 16'd20,    16'd6,     1,  16'd26,    1'b0, 1'b0, 1'b0);
    run_op("sub_20_6",    4'b0101, 16'd20,    16'd6,     1,  16'd14,    1'b0, 1'b0, 1'b0);
    run_op("sub_6_20",    4'b0101, 16'd6,     16'd20,    1,  16'd65522, 1'b0, 1'b1, 1'b0);
    run_op("add_wrap",    4'b0011, 16'd65535, 16'd1,     1,  16'd0,     1'b1, 1'b1, 1'b0);
    run_op("mul_20_6",    4'b0110, 16'd20,    16'd6,     17, 16'd120,   1'b0, 1'b0, 1'b0);
    run_op("mul_300_300", 4'b0110, 16'd300,   16'd300,   17, 16'd24464, 1'b0, 1'b1, 1'b0);
    run_op("mul_max",     4'b0110, 16'd65535, 16'd65535, 17, 16'd1,     1'b0, 1'b1, 1'b0);
    run_op("div_20_6",    4'b0111, 16'd20,    16'd6,     17, 16'd3,     1'b0, 1'b0, 1'b0);
    run_op("mod_20_6",    4'b1000, 16'd20,    16'd6,     17, 16'd2,     1'b0, 1'b0, 1'b0);
    run_op("div_big",     4'b0111, 16'd65535, 16'd7,     17, 16'd9362,  1'b0, 1'b0, 1'b0);
    run_op("mod_big",     4'b1000, 16'd65535, 16'd7,     17, 16'd1,     1'b0, 1'b0, 1'b0);
    run_op("div_by_zero", 4'b0111, 16'd20,    16'd0,     1,  16'd65535, 1'b0, 1'b0, 1'b1);
    run_op("mod_by_zero", 4'b1000, 16'd20,    16'd0,     1,  16'd20,    1'b0, 1'b0, 1'b1);
    run_op("illegal_op",  4'b0100, 16'd20,    16'd6,     1,  16'd0,     1'b1, 1'b0, 1'b1);

    // Backpressure: result must hold and no new command may slip in
    cmd_valid = 1'b1; cmd_op = 4'b0011; cmd_a = 16'd20; cmd_b = 16'd6;
    step();
    cmd_op = 4'b0011; cmd_a = 16'd1; cmd_b = 16'd1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {res_valid, cmd_ready, res_zero, res_carry, res_err, 11'd0, res_data},
          {1'b1, 1'b0, 3'b000, 11'd0, 16'd26});
      step();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_release", {30'd0, res_valid, cmd_ready}, 32'd1);
    step();
    chk("bp_no_ghost", {30'd0, res_valid, cmd_ready}, 32'd1);

    // HALT, then a command that must be ignored
    cmd_valid = 1'b1; cmd_op = 4'b1111;
    step();
    cmd_op = 4'b0011; cmd_a = 16'd20; cmd_b = 16'd6;
    chk("halt_state", {29'd0, halted, cmd_ready, busy}, 32'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_no_result", {29'd0, halted, cmd_ready, res_valid}, 32'd4);
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("halt_reset", {30'd0, halted, cmd_ready}, 32'd1);

    // Reset during DIV, with a competing command on the reset edge
    cmd_valid = 1'b1; cmd_op = 4'b0111; cmd_a = 16'd20; cmd_b = 16'd6;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("div_busy_before_abort", 32'(busy), 32'd1);
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'b0011; cmd_a = 16'd1; cmd_b = 16'd2;
    step();
    reset = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_state", {29'd0, busy, res_valid, cmd_ready}, 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 25; i++) begin
        step();
        if (res_valid || busy) seen++;
      end
      chk("abort_no_result", 32'(seen), 32'd0);
    end
    run_op("add_after_abort", 4'b0011, 16'd20, 16'd6, 1, 16'd26, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
